// File: rtl/ravenoc_pkg.sv
// Shared router parameters and small helpers for the link arbiter slice.
package ravenoc_pkg;

    localparam int unsigned N_VIRT_CHN  = 3;
    localparam int unsigned FLIT_WIDTH  = 34;
    localparam int unsigned FLIT_BUFF   = 4;
    localparam int unsigned VC_ID_WIDTH = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;

    typedef logic [VC_ID_WIDTH-1:0] vc_id_t;
    typedef logic [FLIT_WIDTH-1:0]  flit_t;

    // Modulo-n increment used for round-robin pointer advance.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/vc_link_arbiter_if.sv
// VC buffer pop side plus output link, grouped as one bundle.
interface vc_link_arbiter_if
    import ravenoc_pkg::*;
#(
    parameter int unsigned N_VIRT_CHN  = ravenoc_pkg::N_VIRT_CHN,
    parameter int unsigned FLIT_WIDTH  = ravenoc_pkg::FLIT_WIDTH,
    parameter int unsigned VC_ID_WIDTH = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1
);
    logic [N_VIRT_CHN-1:0][FLIT_WIDTH-1:0] vc_fdata_i;
    logic [N_VIRT_CHN-1:0]                 vc_valid_i;
    logic [N_VIRT_CHN-1:0]                 vc_ready_o;
    logic [N_VIRT_CHN-1:0]                 credit_i;
    logic [FLIT_WIDTH-1:0]                 fdata_o;
    logic                                  valid_o;
    logic [VC_ID_WIDTH-1:0]                vc_id_o;
    logic                                  error_o;

    modport master (
        input  vc_fdata_i, vc_valid_i, credit_i,
        output vc_ready_o, fdata_o, valid_o, vc_id_o, error_o
    );

    modport slave (
        output vc_fdata_i, vc_valid_i, credit_i,
        input  vc_ready_o, fdata_o, valid_o, vc_id_o, error_o
    );
endinterface

// File: rtl/vc_link_arbiter_rr_arbiter.sv
// N-input round-robin arbiter: scans upward from ptr, wrapping, and grants the first requester.
module rr_arbiter #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    int unsigned c;

    // First requester at or after ptr wins; later matches are ignored.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        c       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            c = 32'(ptr) + k;
            if (c >= N) c = c - N;
            if (!gnt_any && req[c]) begin
                gnt_any = 1'b1;
                gnt[c]  = 1'b1;
                gnt_idx = IW'(c);
            end
        end
    end

endmodule

// File: rtl/vc_link_arbiter.sv
// Shares one flit link among VC buffers with per-VC credit tracking and round-robin grant.
module vc_link_arbiter
    import ravenoc_pkg::*;
#(
    parameter int unsigned N_VIRT_CHN = ravenoc_pkg::N_VIRT_CHN,
    parameter int unsigned FLIT_WIDTH = ravenoc_pkg::FLIT_WIDTH,
    parameter int unsigned FLIT_BUFF  = ravenoc_pkg::FLIT_BUFF
) (
    input logic              clk,
    input logic              arst,
    vc_link_arbiter_if.master lnk
);

    localparam int unsigned IW = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1;
    localparam int unsigned CW = $clog2(FLIT_BUFF + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(FLIT_BUFF);

    logic [N_VIRT_CHN-1:0] elig;
    logic [N_VIRT_CHN-1:0] gnt;
    logic [N_VIRT_CHN-1:0] ovf;
    logic                  gnt_any;
    logic [IW-1:0]         gnt_idx;
    logic [IW-1:0]         rr_ptr;
    logic [CW-1:0]         credit_cnt [N_VIRT_CHN];

    logic [FLIT_WIDTH-1:0] fdata_q;
    logic                  valid_q;
    logic [IW-1:0]         vc_id_q;
    logic                  error_q;

    rr_arbiter #(.N(N_VIRT_CHN), .IW(IW)) u_rr_arbiter (
        .req     (elig),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Pop strobe is the live grant, suppressed while reset is held.
    assign lnk.vc_ready_o = arst ? '0 : gnt;

    for (genvar v = 0; v < N_VIRT_CHN; v++) begin : g_cred
        assign elig[v] = lnk.vc_valid_i[v] && (credit_cnt[v] != '0);
        assign ovf[v]  = lnk.credit_i[v] && !gnt[v] && (credit_cnt[v] == CRED_MAX);

        // Grant consumes a downstream slot, credit returns one; both together cancel.
        always_ff @(posedge clk) begin
            if (arst) begin
                credit_cnt[v] <= CRED_MAX;
            end else begin
                case ({gnt[v], lnk.credit_i[v]})
                    2'b10:   credit_cnt[v] <= credit_cnt[v] - CW'(1);
                    2'b01:   if (credit_cnt[v] != CRED_MAX) credit_cnt[v] <= credit_cnt[v] + CW'(1);
                    default: credit_cnt[v] <= credit_cnt[v];
                endcase
            end
        end
    end

    // Link register and round-robin pointer; data and id hold when idle.
    always_ff @(posedge clk) begin
        if (arst) begin
            valid_q <= 1'b0;
            fdata_q <= '0;
            vc_id_q <= '0;
            rr_ptr  <= '0;
        end else begin
            valid_q <= gnt_any;
            if (gnt_any) begin
                fdata_q <= lnk.vc_fdata_i[gnt_idx];
                vc_id_q <= gnt_idx;
                rr_ptr  <= IW'(wrap_inc(32'(gnt_idx), N_VIRT_CHN));
            end
        end
    end

    // Sticky flag for a credit returned to an already-full counter.
    always_ff @(posedge clk) begin
        if (arst) begin
            error_q <= 1'b0;
        end else if (ovf != '0) begin
            error_q <= 1'b1;
        end
    end

    assign lnk.fdata_o = fdata_q;
    assign lnk.valid_o = valid_q;
    assign lnk.vc_id_o = vc_id_q;
    assign lnk.error_o = error_q;

    credit_overflow: assert property (@(posedge clk) disable iff (arst) ovf == '0)
        else $warning("vc_link_arbiter: credit overflow, vc mask %b", ovf);

endmodule

// File: tb/tb_vc_link_arbiter.sv
// Bench for vc_link_arbiter: vector table, directed corner sequences, random run against a model.
module tb_vc_link_arbiter;
    import ravenoc_pkg::*;

    localparam int unsigned NV = N_VIRT_CHN;
    localparam int unsigned FW = FLIT_WIDTH;
    localparam int unsigned FB = FLIT_BUFF;

    typedef struct {
        logic          arst;
        logic [NV-1:0] valid;
        logic [NV-1:0] credit;
        logic [NV-1:0] exp_ready;
        logic          exp_valid;
        vc_id_t        exp_id;
        logic          exp_err;
    } vec_t;

    logic clk;
    logic arst;
    vc_link_arbiter_if lnk ();

    vc_link_arbiter dut (
        .clk  (clk),
        .arst (arst),
        .lnk  (lnk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    logic [FW-1:0] cur_data [NV];

    // Reference model state.
    int      m_cred [NV];
    int      m_rr;
    bit      m_err;
    bit      m_valid;
    logic [FW-1:0] m_fdata;
    int      m_id;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic a, input logic [NV-1:0] vv, input logic [NV-1:0] cr);
        arst           = a;
        lnk.vc_valid_i = vv;
        lnk.credit_i   = cr;
        for (int v = 0; v < int'(NV); v++) begin
            cur_data[v]       = FW'({$urandom(), $urandom()});
            lnk.vc_fdata_i[v] = cur_data[v];
        end
    endtask

    // One cycle: drive, check pop strobe, clock, check the link register.
    task automatic step_chk(input string name, input logic a, input logic [NV-1:0] vv,
                            input logic [NV-1:0] cr, input logic [NV-1:0] er,
                            input logic ev, input vc_id_t eid, input logic eerr);
        logic [FW-1:0] ef;
        drive(a, vv, cr);
        #2;
        check({name, " vc_ready"}, 64'(lnk.vc_ready_o), 64'(er));
        ef = '0;
        for (int v = 0; v < int'(NV); v++) if (er[v]) ef = cur_data[v];
        @(posedge clk);
        #1;
        check({name, " valid"}, 64'(lnk.valid_o), 64'(ev));
        if (ev) begin
            check({name, " vc_id"}, 64'(lnk.vc_id_o), 64'(eid));
            check({name, " fdata"}, 64'(lnk.fdata_o), 64'(ef));
        end
        check({name, " error"}, 64'(lnk.error_o), 64'(eerr));
    endtask

    task automatic check_creds(input string name, input int exp);
        for (int v = 0; v < int'(NV); v++)
            check($sformatf("%s credit%0d", name, v), 64'(dut.credit_cnt[v]), 64'(exp));
    endtask

    vec_t tbl [14];

    initial begin
        logic          a;
        logic [NV-1:0] vv, cr, er;
        int            g;
        int            vi;

        checks = 0;
        errors = 0;
        arst = 1'b1;
        lnk.vc_valid_i = '0;
        lnk.credit_i   = '0;
        lnk.vc_fdata_i = '0;
        @(posedge clk);
        #1;

        // Round-robin over three always-valid VCs until every credit is spent.
        tbl[0] = '{arst: 1'b1, valid: 3'b000, credit: 3'b000, exp_ready: 3'b000,
                   exp_valid: 1'b0, exp_id: '0, exp_err: 1'b0};
        for (int i = 1; i <= 12; i++) begin
            tbl[i] = '{arst: 1'b0, valid: 3'b111, credit: 3'b000,
                       exp_ready: 3'(1 << ((i - 1) % 3)),
                       exp_valid: 1'b1, exp_id: vc_id_t'((i - 1) % 3), exp_err: 1'b0};
        end
        tbl[13] = '{arst: 1'b0, valid: 3'b111, credit: 3'b000, exp_ready: 3'b000,
                    exp_valid: 1'b0, exp_id: '0, exp_err: 1'b0};
        for (int i = 0; i < 14; i++) begin
            step_chk($sformatf("tbl%0d", i), tbl[i].arst, tbl[i].valid, tbl[i].credit,
                     tbl[i].exp_ready, tbl[i].exp_valid, tbl[i].exp_id, tbl[i].exp_err);
            if (i == 0) begin
                check("reset fdata", 64'(lnk.fdata_o), 64'(0));
                check("reset vc_id", 64'(lnk.vc_id_o), 64'(0));
                check_creds("reset", int'(FB));
            end
        end
        check_creds("drained", 0);

        // Lone VC1 drains its credit, stalls, resumes the cycle after a returned credit.
        step_chk("s2 rst", 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, '0, 1'b0);
        for (int i = 0; i < int'(FB); i++)
            step_chk("s2 pop", 1'b0, 3'b010, 3'b000, 3'b010, 1'b1, vc_id_t'(1), 1'b0);
        step_chk("s2 stall", 1'b0, 3'b010, 3'b010, 3'b000, 1'b0, '0, 1'b0);
        step_chk("s2 resume", 1'b0, 3'b010, 3'b000, 3'b010, 1'b1, vc_id_t'(1), 1'b0);

        // With the pointer at 1, VC2 beats VC0.
        step_chk("s3 rst", 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, '0, 1'b0);
        step_chk("s3 vc0", 1'b0, 3'b001, 3'b000, 3'b001, 1'b1, vc_id_t'(0), 1'b0);
        step_chk("s3 vc2 first", 1'b0, 3'b101, 3'b000, 3'b100, 1'b1, vc_id_t'(2), 1'b0);
        step_chk("s3 vc0 next", 1'b0, 3'b101, 3'b000, 3'b001, 1'b1, vc_id_t'(0), 1'b0);

        // Grant and credit on VC0 in the same cycle leave the count unchanged.
        step_chk("s4 take", 1'b0, 3'b001, 3'b000, 3'b001, 1'b1, vc_id_t'(0), 1'b0);
        check("s4 cred before", 64'(dut.credit_cnt[0]), 64'(1));
        step_chk("s4 same cycle", 1'b0, 3'b001, 3'b001, 3'b001, 1'b1, vc_id_t'(0), 1'b0);
        check("s4 cred held", 64'(dut.credit_cnt[0]), 64'(1));
        step_chk("s4 again", 1'b0, 3'b001, 3'b000, 3'b001, 1'b1, vc_id_t'(0), 1'b0);
        step_chk("s4 empty", 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, '0, 1'b0);
        check("s4 cred zero", 64'(dut.credit_cnt[0]), 64'(0));

        // Credit into a full VC2 counter raises the sticky error and saturates.
        step_chk("s5 rst", 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, '0, 1'b0);
        step_chk("s5 overflow", 1'b0, 3'b000, 3'b100, 3'b000, 1'b0, '0, 1'b1);
        check("s5 cred sat", 64'(dut.credit_cnt[2]), 64'(FB));
        step_chk("s5 sticky", 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, '0, 1'b1);

        // Reset in the middle of a VC1 stream clears output, error and credits.
        for (int i = 0; i < 3; i++)
            step_chk("s6 pop", 1'b0, 3'b010, 3'b000, 3'b010, 1'b1, vc_id_t'(1), 1'b1);
        step_chk("s6 rst", 1'b1, 3'b010, 3'b000, 3'b000, 1'b0, '0, 1'b0);
        check_creds("s6", int'(FB));

        // Random traffic against the reference model.
        for (int v = 0; v < int'(NV); v++) m_cred[v] = int'(FB);
        m_rr = 0; m_err = 0; m_valid = 0; m_fdata = '0; m_id = 0;
        for (int n = 0; n < 600; n++) begin
            a  = (n == 0) || ($urandom_range(0, 63) == 0);
            vv = NV'($urandom());
            cr = '0;
            for (int v = 0; v < int'(NV); v++)
                if (m_cred[v] < int'(FB) && $urandom_range(0, 2) == 0) cr[v] = 1'b1;
            drive(a, vv, cr);

            g  = -1;
            er = '0;
            if (!a) begin
                for (int k = 0; k < int'(NV); k++) begin
                    vi = (m_rr + k) % int'(NV);
                    if (g < 0 && vv[vi] && m_cred[vi] > 0) g = vi;
                end
            end
            if (g >= 0) er[g] = 1'b1;
            #2;
            check("rnd vc_ready", 64'(lnk.vc_ready_o), 64'(er));

            if (a) begin
                for (int v = 0; v < int'(NV); v++) m_cred[v] = int'(FB);
                m_rr = 0; m_err = 0; m_valid = 0; m_fdata = '0; m_id = 0;
            end else begin
                for (int v = 0; v < int'(NV); v++) begin
                    m_cred[v] = m_cred[v] + int'(cr[v]) - ((g == v) ? 1 : 0);
                    if (m_cred[v] > int'(FB)) begin
                        m_cred[v] = int'(FB);
                        m_err     = 1;
                    end
                end
                m_valid = (g >= 0);
                if (g >= 0) begin
                    m_fdata = cur_data[g];
                    m_id    = g;
                    m_rr    = (g + 1) % int'(NV);
                end
            end

            @(posedge clk);
            #1;
            check("rnd valid", 64'(lnk.valid_o), 64'(m_valid));
            check("rnd error", 64'(lnk.error_o), 64'(m_err));
            check("rnd vc_id", 64'(lnk.vc_id_o), 64'(m_id));
            check("rnd fdata", 64'(lnk.fdata_o), 64'(m_fdata));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vc_link_arbiter.md
Name: vc_link_arbiter

Overview:
- Output-link scheduler that shares one physical flit link between N_VIRT_CHN virtual-channel buffers.
- Sits between the per-VC flit buffers (valid/ready pop side) and the router output port.
- Tracks downstream free slots per VC with credit counters and arbitrates flit-by-flit, round-robin, among VCs that have a flit and credit.
- Output is registered, with one flit per cycle maximum.

Parameters:
- N_VIRT_CHN, default 3: number of virtual channels sharing the link.
- FLIT_WIDTH, default ravenoc_pkg FLIT_WIDTH: flit width in bits.
- FLIT_BUFF, default ravenoc_pkg FLIT_BUFF: downstream per-VC buffer depth, which is also the initial and maximum credit.

Ports:
- clk  in  1  clock.
- arst  in  1  synchronous active-high reset; sampled only on posedge clk.
- vc_fdata_i  in  N_VIRT_CHN x FLIT_WIDTH  head flit of each VC buffer.
- vc_valid_i  in  N_VIRT_CHN  VC buffer holds a flit.
- vc_ready_o  out  N_VIRT_CHN  one-hot pop strobe to the granted VC buffer.
- credit_i  in  N_VIRT_CHN  downstream freed one slot of VC v (pulse, one per VC per cycle max).
- fdata_o  out  FLIT_WIDTH  link flit, registered.
- valid_o  out  1  link flit valid, registered; link has no backpressure.
- vc_id_o  out  $clog2(N_VIRT_CHN)  VC of fdata_o, registered.
- error_o  out  1  sticky credit-overflow flag.

Behaviour:
- Reset (arst=1 at posedge) applies to all sequential state:
  - credit_cnt[v]=FLIT_BUFF for all v; rr_ptr=0.
  - valid_o=0, fdata_o=0, vc_id_o=0, error_o=0.
  - vc_ready_o=0 while arst is high.
  - Reset mid-packet discards in-flight state; no flit is emitted in the reset cycle.
- Eligibility: elig[v] = vc_valid_i[v] && credit_cnt[v]!=0.
- Arbitration (combinational, same cycle):
  - Grant the first eligible VC scanning from rr_ptr upward, wrapping at N_VIRT_CHN-1 -> 0.
  - No eligible VC: no grant, vc_ready_o=0.
- Pop: vc_ready_o[g]=1 only for the granted g. The VC buffer pops on valid&&ready in that cycle.
- Output register:
  - On grant: next cycle valid_o=1, fdata_o=vc_fdata_i[g], vc_id_o=g.
  - No grant: valid_o=0; fdata_o and vc_id_o hold their previous values.
  - Latency is exactly 1 cycle from pop to link.
- rr_ptr: after a grant to g, rr_ptr <= (g+1) mod N_VIRT_CHN. With no grant, rr_ptr holds. Any single continuously-eligible VC is served within N_VIRT_CHN grants.
- Credits:
  - counter width $clog2(FLIT_BUFF+1).
  - Grant to v decrements credit_cnt[v]; credit_i[v] increments it.
  - Grant and credit_i on the same VC in the same cycle: net unchanged.
  - A credit of 0 blocks v until credit_i[v] arrives. The credit is usable in the cycle after the pulse, not the same cycle.
- Overflow: credit_i[v] with credit_cnt[v]==FLIT_BUFF and no same-cycle grant on v:
  - counter saturates at FLIT_BUFF;
  - error_o <= 1 and stays set until reset.
  - A simulation assertion fires.
- Flit type is not interpreted: head/body/tail flits interleave freely across VCs, because the downstream buffers are per VC.
- Single-flit packets (HEAD, pkt_size==0) need no special handling.

Decomposition:
- ravenoc_pkg holds N_VIRT_CHN, FLIT_WIDTH, FLIT_BUFF, and a typedef vc_id_t = logic [$clog2(N_VIRT_CHN)-1:0].
- One natural sub-module is rr_arbiter (N-input round-robin with pointer input, one-hot grant output and encoded grant index). It is reused by other router output ports.
- Credit counters stay inline as a generate loop.

Test Plan:
- Reset, then all 3 VCs valid continuously with FLIT_BUFF=4 and no credits:
  - vc_id_o sequence is 0,1,2,0,1,2,0,1,2,0,1,2;
  - valid_o then drops to 0, with all credit_cnt=0.
- Only VC1 valid, FLIT_BUFF=2, credit_i[1] pulsed the cycle after the second grant:
  - two flits go out back to back, then one idle cycle, then the third flit goes out.
- VC0 and VC2 valid, rr_ptr=1:
  - VC2 is granted first, then VC0;
  - fdata_o equals the popped vc_fdata_i one cycle after vc_ready_o.
- Same-cycle grant and credit_i on VC0 with credit_cnt[0]=1: the counter stays 1, and VC0 is granted again next cycle.
- credit_i[2] pulsed at credit_cnt[2]=FLIT_BUFF: error_o rises the next cycle and stays 1; the counter stays at FLIT_BUFF.
- arst asserted while VC1 is mid-stream (3 flits sent): the next cycle has valid_o=0 and error_o=0, and all credits are restored to FLIT_BUFF.
